mc_control_fsm: RTL

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_if.sv | 37 +++
 rtl/mc_control_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle controller and its datapath.
//   op         : opcode from the instruction register (datapath -> controller)
//   mem_ready  : memory completes the current access this cycle
//   mem_req, pc_update, branch, ir_write, adr_src, mem_write, reg_write,
//   result_src, alu_src_a, alu_src_b, alu_op : datapath control strobes/selects
//   state_o    : current controller state code
//   illegal_o  : sticky illegal-opcode flag
// Modports: master = controller side, slave = datapath side.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state_o;
  logic       illegal_o;

  modport master (
    input  op, mem_ready,
    output mem_req, pc_update, branch, ir_write, adr_src, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, state_o, illegal_o
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, pc_update, branch, ir_write, adr_src, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, state_o, illegal_o
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V style main controller FSM.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   ctrl   : mc_control_fsm_if.master (opcode/mem_ready in, datapath controls out)
// Parameters:
//   MEM_WAIT : 1 = memory states wait for mem_ready, 0 = mem_ready treated as 1
//   JAL_EN   : 1 = jal opcode decoded, 0 = jal treated as illegal
//   TRAP_EN  : 1 = illegal opcode parks in TRAP, 0 = illegal opcode returns to FETCH
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned JAL_EN   = 1,
  parameter int unsigned TRAP_EN  = 1
) (
  input logic              clk,
  input logic              rst_n,
  mc_control_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e r_state;
  state_e w_state_next;
  state_e w_decode_next;
  state_e w_out_state;
  logic   r_illegal;
  logic   w_ready;
  logic   w_op_legal;

  assign w_ready = (MEM_WAIT == 0) || ctrl.mem_ready;

  // Opcode decode, used only when leaving DECODE.
  always_comb begin
    w_op_legal    = 1'b1;
    w_decode_next = StFetch;
    case (ctrl.op)
      OpLoad, OpStore: w_decode_next = StMemAdr;
      OpRType:         w_decode_next = StExecR;
      OpIType:         w_decode_next = StExecI;
      OpBranch:        w_decode_next = StBeq;
      OpJal: begin
        if (JAL_EN != 0) w_decode_next = StJal;
        else             w_op_legal    = 1'b0;
      end
      default:         w_op_legal    = 1'b0;
    endcase
    if (!w_op_legal) w_decode_next = (TRAP_EN != 0) ? StTrap : StFetch;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:    if (w_ready) w_state_next = StDecode;
      StDecode:   w_state_next = w_decode_next;
      StMemAdr:   w_state_next = (ctrl.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (w_ready) w_state_next = StMemWb;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: if (w_ready) w_state_next = StFetch;
      StExecR:    w_state_next = StAluWb;
      StExecI:    w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StJal:      w_state_next = StAluWb;
      StBeq:      w_state_next = StFetch;
      StTrap:     w_state_next = StTrap;
      default:    w_state_next = StFetch;  // unused codes 12-15 recover
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StFetch;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StDecode) && !w_op_legal) r_illegal <= 1'b1;
    end
  end

  // While reset is asserted the controls already show FETCH, so the datapath
  // never sees a stale state's strobes during the reset cycle.
  assign w_out_state = rst_n ? r_state : StFetch;

  always_comb begin
    ctrl.mem_req    = 1'b0;
    ctrl.pc_update  = 1'b0;
    ctrl.branch     = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.adr_src    = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.result_src = 2'b00;
    ctrl.alu_src_a  = 2'b00;
    ctrl.alu_src_b  = 2'b00;
    ctrl.alu_op     = 2'b00;
    case (w_out_state)
      StFetch: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.ir_write   = w_ready;
        ctrl.pc_update  = w_ready;
      end
      StDecode: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      StMemRead: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      StMemWb: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      StExecR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = 2'b10;
      end
      StExecI: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b10;
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
      end
      StJal: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_update = 1'b1;
      end
      StBeq: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      default: ;  // TRAP and unused codes drive all zeros
    endcase
  end

  assign ctrl.state_o   = r_state;
  assign ctrl.illegal_o = r_illegal;

endmodule
